// File: rtl/lv_owt_arb_pkg.sv
// rtl/lv_owt_arb_pkg.sv - shared widths, op codes and FSM states for the OWT TX request arbiter
package lv_owt_arb_pkg;

  localparam int REG_AW = 7;
  localparam int REG_DW = 8;

  localparam logic RD_OP = 1'b0;
  localparam logic WR_OP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_DONE
  } arb_state_e;

endpackage

// File: rtl/lv_owt_rr_pick.sv
// rtl/lv_owt_rr_pick.sv - round-robin finder over low-priority slots 1..REQ_NUM-1, starting at ptr
module lv_owt_rr_pick #(
  parameter int REQ_NUM = 3,
  parameter int REQ_IDW = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [REQ_IDW-1:0] ptr,
  output logic               found,
  output logic [REQ_IDW-1:0] idx
);

  // Walk offsets from the far end so the nearest pending slot to ptr is the last write.
  always_comb begin
    int cand;
    found = 1'b0;
    idx   = '0;
    for (int k = REQ_NUM - 2; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= REQ_NUM) cand = cand - (REQ_NUM - 1);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand[REQ_IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/lv_owt_req_arb.sv
// rtl/lv_owt_req_arb.sv - arbitrates register requesters onto the single OWT TX request port
// Optional anti-starvation of low slots under LV_OWT_ARB_STARVE_EN.
module lv_owt_req_arb
  import lv_owt_arb_pkg::*;
#(
  parameter int REQ_NUM    = 3,
  parameter int MAX_RETRY  = 2,
  parameter int GAP_CYC    = 2,
  parameter int STARVE_LMT = 4,
  parameter int REQ_IDW    = $clog2(REQ_NUM)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [REQ_NUM-1:0]        i_req,
  input  logic [REQ_NUM-1:0]        i_req_rw,
  input  logic [REQ_NUM*REG_AW-1:0] i_req_addr,
  input  logic [REQ_NUM*REG_DW-1:0] i_req_data,
  output logic [REQ_NUM-1:0]        o_req_ack,
  output logic [REQ_NUM-1:0]        o_req_err,
  output logic                      o_tx_wr_req,
  output logic                      o_tx_rd_req,
  output logic [REG_AW-1:0]         o_tx_addr,
  output logic [REG_DW-1:0]         o_tx_data,
  input  logic                      i_tx_ack,
  input  logic                      i_tx_rsp_err,
  output logic [REQ_IDW-1:0]        o_grant_id,
  output logic                      o_busy
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  arb_state_e          state_q, state_d;
  logic                rw_q;
  logic [REG_AW-1:0]   addr_q;
  logic [REG_DW-1:0]   data_q;
  logic [REQ_IDW-1:0]  id_q;
  logic [REQ_IDW-1:0]  rr_ptr_q;
  logic                err_q;
  logic                drop_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic [RTY_W-1:0]    retry_cnt_q;

  logic                rr_found;
  logic [REQ_IDW-1:0]  rr_idx;
  logic                force_low;
  logic                grant_en;
  logic [REQ_IDW-1:0]  grant_idx;
  logic                gap_last;
  logic                do_retry;
  logic                ack_fire;

  lv_owt_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .REQ_IDW (REQ_IDW)
  ) u_rr_pick (
    .req   (i_req),
    .ptr   (rr_ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

`ifdef LV_OWT_ARB_STARVE_EN
  localparam int STV_W = $clog2(STARVE_LMT + 1);
  logic [STV_W-1:0] starve_cnt_q;

  // Saturates at the limit; only the >= comparison matters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt_q <= '0;
    end else if (state_q == ST_DONE) begin
      if (id_q != '0) starve_cnt_q <= '0;
      else if (starve_cnt_q < STV_W'(STARVE_LMT)) starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  assign force_low = (starve_cnt_q >= STV_W'(STARVE_LMT)) && rr_found;
`else
  assign force_low = 1'b0;
`endif

  always_comb begin
    grant_en  = 1'b0;
    grant_idx = '0;
    if (i_req[0] && !force_low) begin
      grant_en = 1'b1;
    end else if (rr_found) begin
      grant_en  = 1'b1;
      grant_idx = rr_idx;
    end
  end

  assign gap_last = (gap_cnt_q == GAP_W'(GAP_CYC - 1));
  assign do_retry = err_q && (retry_cnt_q < RTY_W'(MAX_RETRY));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_en) state_d = ST_REQ;
      ST_REQ:  if (i_tx_ack) state_d = ST_GAP;
      ST_GAP:  if (gap_last) state_d = do_retry ? ST_REQ : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      id_q        <= '0;
      rr_ptr_q    <= REQ_IDW'(1);
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      gap_cnt_q   <= '0;
      retry_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (grant_en) begin
          rw_q        <= i_req_rw[grant_idx];
          addr_q      <= i_req_addr[int'(grant_idx)*REG_AW +: REG_AW];
          data_q      <= i_req_data[int'(grant_idx)*REG_DW +: REG_DW];
          id_q        <= grant_idx;
          err_q       <= 1'b0;
          drop_q      <= 1'b0;
          retry_cnt_q <= '0;
        end
        ST_REQ: if (i_tx_ack) begin
          err_q     <= i_tx_rsp_err;
          gap_cnt_q <= '0;
        end
        ST_GAP: begin
          if (!gap_last)     gap_cnt_q   <= gap_cnt_q + 1'b1;
          else if (do_retry) retry_cnt_q <= retry_cnt_q + 1'b1;
        end
        ST_DONE: begin
          retry_cnt_q <= '0;
          if (id_q != '0)
            rr_ptr_q <= (id_q == REQ_IDW'(REQ_NUM - 1)) ? REQ_IDW'(1) : id_q + 1'b1;
        end
        default: ;
      endcase
      // A requester that lets go mid-transaction forfeits its completion pulse.
      if (state_q != ST_IDLE && !i_req[id_q]) drop_q <= 1'b1;
    end
  end

  assign ack_fire = (state_q == ST_DONE) && !drop_q && i_req[id_q];

  always_comb begin
    o_req_ack = '0;
    o_req_err = '0;
    if (ack_fire) begin
      o_req_ack[id_q] = 1'b1;
      o_req_err[id_q] = err_q;
    end
  end

  assign o_tx_wr_req = (state_q == ST_REQ) && (rw_q == WR_OP);
  assign o_tx_rd_req = (state_q == ST_REQ) && (rw_q == RD_OP);
  assign o_tx_addr   = addr_q;
  assign o_tx_data   = data_q;
  assign o_grant_id  = id_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lv_owt_req_arb.sv
// tb/tb_lv_owt_req_arb.sv - directed self-checking bench for lv_owt_req_arb
module tb_lv_owt_req_arb;
  import lv_owt_arb_pkg::*;

  localparam int REQ_NUM = 3;
  localparam int GAP_CYC = 2;
  localparam int REQ_IDW = 2;

  logic                      i_clk;
  logic                      i_rst_n;
  logic [REQ_NUM-1:0]        i_req;
  logic [REQ_NUM-1:0]        i_req_rw;
  logic [REQ_NUM*REG_AW-1:0] i_req_addr;
  logic [REQ_NUM*REG_DW-1:0] i_req_data;
  logic [REQ_NUM-1:0]        o_req_ack;
  logic [REQ_NUM-1:0]        o_req_err;
  logic                      o_tx_wr_req;
  logic                      o_tx_rd_req;
  logic [REG_AW-1:0]         o_tx_addr;
  logic [REG_DW-1:0]         o_tx_data;
  logic                      i_tx_ack;
  logic                      i_tx_rsp_err;
  logic [REQ_IDW-1:0]        o_grant_id;
  logic                      o_busy;
  logic                      tx_req;

  lv_owt_req_arb #(
    .REQ_NUM    (REQ_NUM),
    .MAX_RETRY  (2),
    .GAP_CYC    (GAP_CYC),
    .STARVE_LMT (4),
    .REQ_IDW    (REQ_IDW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req        (i_req),
    .i_req_rw     (i_req_rw),
    .i_req_addr   (i_req_addr),
    .i_req_data   (i_req_data),
    .o_req_ack    (o_req_ack),
    .o_req_err    (o_req_err),
    .o_tx_wr_req  (o_tx_wr_req),
    .o_tx_rd_req  (o_tx_rd_req),
    .o_tx_addr    (o_tx_addr),
    .o_tx_data    (o_tx_data),
    .i_tx_ack     (i_tx_ack),
    .i_tx_rsp_err (i_tx_rsp_err),
    .o_grant_id   (o_grant_id),
    .o_busy       (o_busy)
  );

  assign tx_req = o_tx_wr_req | o_tx_rd_req;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  int         exp_g2[7]  = '{1, 2, 1, 2, 0, 1, 2};
  logic [2:0] reas2[7]   = '{3'b010, 3'b100, 3'b010, 3'b101, 3'b000, 3'b000, 3'b000};
  int         addr2[3]   = '{'h05, 'h21, 'h32};
`ifdef LV_OWT_ARB_STARVE_EN
  int         exp_g6[6]  = '{0, 0, 0, 0, 1, 0};
`else
  int         exp_g6[6]  = '{0, 0, 0, 0, 0, 0};
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_slot(input int s, input logic rw, input logic [6:0] a, input logic [7:0] d);
    i_req_rw[s]                    = rw;
    i_req_addr[s*REG_AW +: REG_AW] = a;
    i_req_data[s*REG_DW +: REG_DW] = d;
  endtask

  // Downstream model: wait for a request level, answer with a one-cycle ack.
  task automatic serve(input logic err, output int low_cyc, output int gid, output int addr);
    low_cyc = 0;
    while (!tx_req && low_cyc < 40) begin
      low_cyc++;
      @(negedge i_clk);
    end
    check("serve_tx_req_seen", tx_req, 1);
    gid          = int'(o_grant_id);
    addr         = int'(o_tx_addr);
    i_tx_ack     = 1'b1;
    i_tx_rsp_err = err;
    @(negedge i_clk);
    i_tx_ack     = 1'b0;
    i_tx_rsp_err = 1'b0;
  endtask

  // Run until idle, collecting completion pulses; requesters drop on their ack.
  task automatic finish_txn(output logic [2:0] acks, output logic [2:0] errs,
                            output int n_ack, output int n_txreq);
    acks = '0; errs = '0; n_ack = 0; n_txreq = 0;
    for (int c = 0; c < 40 && o_busy; c++) begin
      if (o_req_ack != '0) n_ack++;
      if (tx_req) n_txreq++;
      acks  |= o_req_ack;
      errs  |= o_req_err;
      i_req  = i_req & ~o_req_ack;
      @(negedge i_clk);
    end
    check("finish_idle", o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, gid, addr, lat, n_ack, n_tx, slot1_acks;
    logic [2:0] acks, errs;
    logic ack_seen, busy_seen;

    i_rst_n = 1'b0; i_req = '0; i_req_rw = '0; i_req_addr = '0; i_req_data = '0;
    i_tx_ack = 1'b0; i_tx_rsp_err = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_wr_req", o_tx_wr_req, 0);
    check("rst_rd_req", o_tx_rd_req, 0);
    check("rst_ack_err", {o_req_ack, o_req_err}, 0);
    check("rst_busy_grant", {o_busy, o_grant_id}, 0);
    check("rst_addr_data", {o_tx_addr, o_tx_data}, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    i_tx_ack = 1'b1;
    @(negedge i_clk);
    i_tx_ack = 1'b0;
    check("stray_ack_busy", o_busy, 0);
    @(negedge i_clk);

    // 1: slot 0 write, clean
    set_slot(0, 1'b1, 7'h12, 8'hA5);
    i_req[0] = 1'b1;
    @(negedge i_clk);
    check("t1_wr_req", o_tx_wr_req, 1);
    check("t1_rd_req", o_tx_rd_req, 0);
    check("t1_addr", o_tx_addr, 'h12);
    check("t1_data", o_tx_data, 'hA5);
    check("t1_grant", o_grant_id, 0);
    repeat (2) @(negedge i_clk);
    check("t1_wr_hold", o_tx_wr_req, 1);
    check("t1_addr_hold", {o_tx_addr, o_tx_data}, {7'h12, 8'hA5});
    i_tx_ack = 1'b1;
    @(negedge i_clk);
    i_tx_ack = 1'b0;
    check("t1_req_low", tx_req, 0);
    lat = 1;
    while (!o_req_ack[0] && lat < 10) begin
      @(negedge i_clk);
      lat++;
    end
    check("t1_ack_latency", lat, GAP_CYC + 1);
    check("t1_ack_vec", o_req_ack, 3'b001);
    check("t1_err", o_req_err, 0);
    i_req[0] = 1'b0;
    @(negedge i_clk);
    check("t1_idle", o_busy, 0);
    check("t1_addr_keep", o_tx_addr, 'h12);

    // 2: round robin 1/2 with slot 0 cutting in
    set_slot(0, 1'b1, 7'h05, 8'h55);
    set_slot(1, 1'b1, 7'h21, 8'h11);
    set_slot(2, 1'b0, 7'h32, 8'h22);
    i_req = 3'b110;
    for (int t = 0; t < 7; t++) begin
      serve(1'b0, low, gid, addr);
      check($sformatf("t2_grant%0d", t), gid, exp_g2[t]);
      check($sformatf("t2_addr%0d", t), addr, addr2[exp_g2[t]]);
      finish_txn(acks, errs, n_ack, n_tx);
      check($sformatf("t2_ack%0d", t), acks, 3'b001 << exp_g2[t]);
      i_req = i_req | reas2[t];
    end

    // 3: read errored on every attempt
    set_slot(1, 1'b0, 7'h44, 8'h00);
    i_req = 3'b010;
    for (int a = 0; a < 3; a++) begin
      serve(1'b1, low, gid, addr);
      check($sformatf("t3_grant%0d", a), gid, 1);
      if (a > 0) check($sformatf("t3_gap%0d", a), low >= GAP_CYC, 1);
    end
    finish_txn(acks, errs, n_ack, n_tx);
    check("t3_extra_tx", n_tx, 0);
    check("t3_ack_cnt", n_ack, 1);
    check("t3_ack", acks, 3'b010);
    check("t3_err", errs, 3'b010);

    // 4: errored then clean
    set_slot(2, 1'b1, 7'h55, 8'h3C);
    i_req = 3'b100;
    serve(1'b1, low, gid, addr);
    serve(1'b0, low, gid, addr);
    check("t4_retry_addr", addr, 'h55);
    finish_txn(acks, errs, n_ack, n_tx);
    check("t4_extra_tx", n_tx, 0);
    check("t4_ack", acks, 3'b100);
    check("t4_err", errs, 3'b000);

    // 5a: requester drops mid-transaction
    set_slot(1, 1'b1, 7'h66, 8'h77);
    i_req = 3'b010;
    @(negedge i_clk);
    check("t5_wr_req", o_tx_wr_req, 1);
    i_req[1] = 1'b0;
    serve(1'b0, low, gid, addr);
    finish_txn(acks, errs, n_ack, n_tx);
    check("t5_no_ack", acks, 3'b000);

    // 5b: async reset while in REQ
    set_slot(2, 1'b1, 7'h70, 8'h0F);
    i_req = 3'b100;
    @(negedge i_clk);
    check("t5_req_before_rst", tx_req, 1);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("t5_rst_tx_req", tx_req, 0);
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_addr", o_tx_addr, 0);
    repeat (2) @(negedge i_clk);
    i_req   = '0;
    i_rst_n = 1'b1;
    ack_seen = 1'b0; busy_seen = 1'b0;
    repeat (8) begin
      @(negedge i_clk);
      ack_seen  |= |o_req_ack;
      busy_seen |= o_busy;
    end
    check("t5_post_rst_ack", ack_seen, 0);
    check("t5_post_rst_busy", busy_seen, 0);

    // 6: slot 0 continuous, slot 1 pending
    set_slot(0, 1'b1, 7'h01, 8'h10);
    set_slot(1, 1'b1, 7'h02, 8'h20);
    i_req = 3'b011;
    slot1_acks = 0;
    for (int t = 0; t < 6; t++) begin
      serve(1'b0, low, gid, addr);
      check($sformatf("t6_grant%0d", t), gid, exp_g6[t]);
      finish_txn(acks, errs, n_ack, n_tx);
      if (acks[1]) slot1_acks++;
      i_req[0] = 1'b1;
    end
`ifdef LV_OWT_ARB_STARVE_EN
    check("t6_slot1_acks", slot1_acks, 1);
`else
    check("t6_slot1_acks", slot1_acks, 0);
`endif
    i_req = '0;
    repeat (3) @(negedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
